// File: rtl/alu.sv
// Registered 8-bit two-mode bitwise ALU with a sticky interrupt flag.
// One operation per enabled clock; the selected set (A or B) picks the function.
module alu (
    input  logic       alu_clk,
    input  logic       rst_n,
    input  logic       alu_irq_clr,
    input  logic       alu_enable,
    input  logic       alu_enable_a,
    input  logic       alu_enable_b,
    input  logic [1:0] alu_op_a,
    input  logic [1:0] alu_op_b,
    input  logic [7:0] alu_in_a,
    input  logic [7:0] alu_in_b,
    output logic [7:0] alu_out,
    output logic       alu_irq
);

    logic       valid;
    logic [7:0] result;
    logic [7:0] flag_value;
    logic       irq_event;

    // Exactly one set enable must be active; both or neither is a hold cycle.
    assign valid = alu_enable && (alu_enable_a ^ alu_enable_b);

    always_comb begin
        result     = 8'h00;
        flag_value = 8'h00;
        if (alu_enable_a) begin
            case (alu_op_a)
                2'b00: begin result = alu_in_a & alu_in_b;    flag_value = 8'hFF; end
                2'b01: begin result = ~(alu_in_a & alu_in_b); flag_value = 8'h00; end
                2'b10: begin result = alu_in_a | alu_in_b;    flag_value = 8'hF8; end
                default: begin result = alu_in_a ^ alu_in_b;  flag_value = 8'h83; end
            endcase
        end else begin
            case (alu_op_b)
                2'b00: begin result = ~(alu_in_a ^ alu_in_b); flag_value = 8'hF1; end
                2'b01: begin result = alu_in_a & alu_in_b;    flag_value = 8'hF4; end
                2'b10: begin result = ~(alu_in_a | alu_in_b); flag_value = 8'hF5; end
                default: begin result = alu_in_a | alu_in_b;  flag_value = 8'hFF; end
            endcase
        end
    end

    assign irq_event = valid && (result == flag_value);

    always_ff @(posedge alu_clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out <= 8'h00;
            alu_irq <= 1'b0;
        end else begin
            if (valid)
                alu_out <= result;
            // Clear wins over a simultaneous event; the result still loads.
            if (alu_irq_clr)
                alu_irq <= 1'b0;
            else if (irq_event)
                alu_irq <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes model predictions, a monitor
// pops and compares them one step after every rising edge.
module tb_alu;

    logic       alu_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alu_irq_clr = 1'b0;
    logic       alu_enable = 1'b0;
    logic       alu_enable_a = 1'b0;
    logic       alu_enable_b = 1'b0;
    logic [1:0] alu_op_a = 2'b00;
    logic [1:0] alu_op_b = 2'b00;
    logic [7:0] alu_in_a = 8'h00;
    logic [7:0] alu_in_b = 8'h00;
    logic [7:0] alu_out;
    logic       alu_irq;

    alu dut (
        .alu_clk(alu_clk), .rst_n(rst_n), .alu_irq_clr(alu_irq_clr),
        .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_out(alu_out), .alu_irq(alu_irq)
    );

    always #5 alu_clk = ~alu_clk;

    typedef struct {
        logic [7:0] out;
        logic       irq;
        string      name;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    logic [7:0] m_out = 8'h00;
    logic       m_irq = 1'b0;
    bit seen_op[8];
    bit seen_irq[8];

    logic [7:0] flags_a[4] = '{8'hFF, 8'h00, 8'hF8, 8'h83};
    logic [7:0] flags_b[4] = '{8'hF1, 8'hF4, 8'hF5, 8'hFF};
    logic [7:0] pool[9] = '{8'h00, 8'hFF, 8'hF0, 8'h0F, 8'hF8, 8'h83, 8'hF1, 8'hF4, 8'h0A};

    function automatic logic [7:0] compute(bit set_b, int op, logic [7:0] a, logic [7:0] b);
        if (!set_b) begin
            if (op == 0) return a & b;
            if (op == 1) return ~(a & b);
            if (op == 2) return a | b;
            return a ^ b;
        end
        if (op == 0) return ~(a ^ b);
        if (op == 1) return a & b;
        if (op == 2) return ~(a | b);
        return a | b;
    endfunction

    task automatic check(string name, logic [7:0] got_o, logic got_i, logic [7:0] exp_o, logic exp_i);
        tests++;
        if (got_o !== exp_o) begin
            fails++;
            $display("FAIL %s out: got %02h expected %02h", name, got_o, exp_o);
        end
        tests++;
        if (got_i !== exp_i) begin
            fails++;
            $display("FAIL %s irq: got %0b expected %0b", name, got_i, exp_i);
        end
    endtask

    // Applies one cycle of inputs at the falling edge and predicts the state after the next rising edge.
    task automatic drive(string name, bit rst_val, bit clr, bit en, bit ea, bit eb,
                         int opa, int opb, logic [7:0] a, logic [7:0] b);
        bit valid;
        bit hit;
        logic [7:0] res;
        exp_t e;
        @(negedge alu_clk);
        rst_n = rst_val; alu_irq_clr = clr; alu_enable = en;
        alu_enable_a = ea; alu_enable_b = eb;
        alu_op_a = 2'(opa); alu_op_b = 2'(opb); alu_in_a = a; alu_in_b = b;
        if (!rst_val) begin
            m_out = 8'h00;
            m_irq = 1'b0;
        end else begin
            valid = en && (ea != eb);
            hit = 1'b0;
            if (valid) begin
                res = compute(eb, eb ? opb : opa, a, b);
                hit = (res == (eb ? flags_b[opb] : flags_a[opa]));
                m_out = res;
                seen_op[(eb ? 4 : 0) + (eb ? opb : opa)] = 1'b1;
                if (hit) seen_irq[(eb ? 4 : 0) + (eb ? opb : opa)] = 1'b1;
            end
            if (clr) m_irq = 1'b0;
            else if (hit) m_irq = 1'b1;
        end
        e.out = m_out; e.irq = m_irq; e.name = name;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge alu_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.name, alu_out, alu_irq, e.out, e.irq);
            end
        end
    end

    initial begin : stimulus
        int en_sel;
        #3;
        check("reset_initial", alu_out, alu_irq, 8'h00, 1'b0);
        drive("in_reset", 0, 0, 1, 1, 0, 0, 0, 8'hFF, 8'hFF);

        // Set A sweep, then set B sweep, with the other opcode deliberately mismatched.
        for (int i = 0; i < 4; i++) drive("set_a_sweep", 1, 0, 1, 1, 0, i, 3 - i, 8'hF0, 8'h3C);
        for (int i = 0; i < 4; i++) drive("set_b_sweep", 1, 0, 1, 0, 1, 3 - i, i, 8'hF0, 8'h3C);

        drive("irq_set", 1, 0, 1, 1, 0, 0, 0, 8'hFF, 8'hFF);
        drive("irq_sticky", 1, 0, 1, 1, 0, 2, 0, 8'h12, 8'h34);
        drive("irq_clear", 1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        drive("irq_set_again", 1, 0, 1, 1, 0, 0, 0, 8'hFF, 8'hFF);
        drive("clr_beats_set", 1, 1, 1, 0, 1, 0, 3, 8'hF0, 8'h0F);

        drive("hold_load", 1, 0, 1, 1, 0, 0, 0, 8'hF0, 8'h3C);
        drive("invalid_both", 1, 0, 1, 1, 1, 0, 3, 8'hFF, 8'hFF);
        drive("invalid_disabled", 1, 0, 0, 1, 0, 0, 0, 8'hFF, 8'hFF);
        drive("invalid_none", 1, 0, 1, 0, 0, 0, 3, 8'hFF, 8'hFF);

        // Asynchronous reset between edges, held across edges with valid inputs.
        drive("pre_reset", 1, 0, 1, 1, 0, 0, 0, 8'hFF, 8'hFF);
        @(posedge alu_clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_async", alu_out, alu_irq, 8'h00, 1'b0);
        drive("reset_hold1", 0, 0, 1, 1, 0, 0, 0, 8'hFF, 8'hFF);
        drive("reset_hold2", 0, 0, 1, 0, 1, 3, 3, 8'hF0, 8'h0F);
        drive("first_after_reset", 1, 0, 1, 1, 0, 3, 0, 8'h83, 8'h00);

        for (int n = 0; n < 1500; n++) begin
            en_sel = $urandom_range(0, 15);
            drive("random", 1, ($urandom_range(0, 7) == 0), (en_sel != 0), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 9) ? 8'($urandom) : pool[$urandom_range(0, 8)],
                  ($urandom_range(0, 9) == 9) ? 8'($urandom) : pool[$urandom_range(0, 8)]);
        end

        repeat (3) @(negedge alu_clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        for (int k = 0; k < 8; k++)
            if (!seen_op[k] || !seen_irq[k])
                $display("[TB] note: coverage gap at op index %0d (op %0b irq %0b)", k, seen_op[k], seen_irq[k]);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Registered 8-bit two-mode logic ALU with a sticky interrupt flag. It sits behind the `alu_ifc` interface and is driven by the verification environment's driver. Each enabled clock computes one bitwise operation from operation set A or set B on two 8-bit operands. It raises `alu_irq` when the result matches a per-operation flag value.

## Interface
- No parameters; all widths are fixed.
- `alu_clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `alu_irq_clr` input 1: clears `alu_irq`.
- `alu_enable` input 1: global enable; when 0, no new operation executes.
- `alu_enable_a` input 1: selects operation set A.
- `alu_enable_b` input 1: selects operation set B.
- `alu_op_a` input 2: opcode within set A.
- `alu_op_b` input 2: opcode within set B.
- `alu_in_a` input 8: operand A.
- `alu_in_b` input 8: operand B.
- `alu_out` output 8: registered result.
- `alu_irq` output 1: registered, sticky interrupt flag.
- Port order at instantiation is exactly the order above.

## Operation
A cycle is valid when `alu_enable`=1 and exactly one of `alu_enable_a`/`alu_enable_b` is 1.

Set A (`alu_enable_a`=1, `alu_enable_b`=0):
- op 00: A AND B; irq event if result = 8'hFF.
- op 01: A NAND B; irq event if result = 8'h00.
- op 10: A OR B; irq event if result = 8'hF8.
- op 11: A XOR B; irq event if result = 8'h83.

Set B (`alu_enable_a`=0, `alu_enable_b`=1):
- op 00: A XNOR B; irq event if result = 8'hF1.
- op 01: A AND B; irq event if result = 8'hF4.
- op 10: A NOR B; irq event if result = 8'hF5.
- op 11: A OR B; irq event if result = 8'hFF.

Rules:
- The opcode of the non-selected set is ignored.
- On a valid cycle, `alu_out` loads the result.
- On a valid cycle with an irq event, `alu_irq` sets to 1.
- Invalid cycles: `alu_enable`=0, both set enables 0, or both set enables 1. `alu_out` holds its value and no irq event is generated.
- `alu_irq` is sticky. Once set, it stays 1 until `alu_irq_clr`=1 is sampled or reset occurs.
- Priority: clear beats set. If `alu_irq_clr`=1 in the same cycle as an irq event, `alu_irq` is 0 after the edge. The result is still loaded.
- `alu_irq_clr` works regardless of `alu_enable`.
- All operations are bitwise; there is no carry, overflow or signedness.

## Timing
- Reset (`rst_n`=0): `alu_out`=8'h00 and `alu_irq`=0 immediately, without waiting for a clock. Both hold while reset is asserted.
- Reset asserted mid-operation discards the pending result.
- The first valid operation is the first rising edge with `rst_n`=1.
- Latency: inputs are sampled at rising edge N, and `alu_out`/`alu_irq` reflect them after edge N.
- Throughput: one operation per clock; no handshake and no back-pressure.
- Back-to-back valid cycles each overwrite `alu_out`.

## Test plan
- Reset: assert `rst_n`=0 mid-run → `alu_out`=00 and `alu_irq`=0 asynchronously; both stay there until the first valid edge after release.
- Set A sweep: A=F0, B=3C, `alu_enable`=1, en_a=1, op_a=00/01/10/11 → `alu_out`=30/CF/FC/CC one cycle later, `alu_irq`=0.
- Set B sweep: A=F0, B=3C, en_b=1, op_b=00/01/10/11 → `alu_out`=33/30/03/FC, `alu_irq`=0.
- IRQ set and clear:
  - Set A op 00, A=FF, B=FF → `alu_out`=FF and `alu_irq`=1.
  - Next cycle, a non-matching op → `alu_irq` stays 1.
  - Pulse `alu_irq_clr` → `alu_irq`=0.
  - Clear asserted alongside a new event (set B op 11, A=F0, B=0F) → `alu_out`=FF, `alu_irq`=0.
- Invalid modes: hold `alu_out`=30. Apply (a) en_a=en_b=1 with A=FF, B=FF; (b) `alu_enable`=0; (c) en_a=en_b=0 → `alu_out` stays 30 and no irq.
- Random regression of 1500 transactions checked against a reference model; cover all 8 opcodes, all 8 irq events, and all invalid-mode combinations.
